lif_array: RTL and testbench
============================

LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 Parameter N, default 4: number of independent LIF neurons.
REQ-002 Parameter W, default 8: membrane state and current width in bits.
REQ-003 Parameter LEAK_SHIFT, default 3: leak term is state >> LEAK_SHIFT.
REQ-004 Parameter REFRAC, default 2: refractory cycles after a spike, 0 to 15; 0 disables refractory.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 ena  input  1  update enable; when 0, all neurons hold.
REQ-008 current  input  N*W  unsigned per-neuron input current; neuron i uses bits [i*W +: W].
REQ-009 thresh  input  W  unsigned firing threshold shared by all neurons; 0 disables firing.
REQ-010 reset_mode  input  1  0 = reset-to-zero on spike; 1 = subtract-threshold on spike.
REQ-011 sel  input  max(1,clog2(N))  neuron index for state readout.
REQ-012 spike  output  N  registered one-cycle spike pulse per neuron.
REQ-013 state_out  output  W  membrane state of neuron sel, combinational mux of registered state.
REQ-014 spike_cnt  output  16  registered saturating count of all spikes from all neurons.

Function
REQ-015 Per neuron: W-bit state register, 4-bit refractory counter, spike flop.
REQ-016 Candidate next = state - (state >> LEAK_SHIFT) + current_i, computed in W+1 bits and saturated to 2^W-1.
REQ-017 Edge with ena=1, refrac_i=0, thresh!=0 and next >= thresh: spike_i<=1, refrac_i<=REFRAC, state<=0 if reset_mode=0, else state<=next-thresh.
REQ-018 Edge with ena=1, refrac_i=0, and no fire condition: spike_i<=0, state<=next.
REQ-019 Edge with ena=1 and refrac_i>0: spike_i<=0, state held, current ignored, no leak, refrac_i decrements by 1.
REQ-020 Edge with ena=0: state, refrac and spike_cnt held; spike_i<=0.
REQ-021 A spike is visible on spike_i in the cycle after the edge that computed the firing next value; the post-spike state is visible in the same cycle.
REQ-022 A neuron fires at most once per REFRAC+1 enabled cycles; with REFRAC=0 it may fire on consecutive enabled cycles.
REQ-023 reset_mode and thresh are sampled on every edge; a change takes effect on the next evaluation with no pipeline delay.
REQ-024 spike_cnt adds the population count of firing neurons on each edge, saturating at 16'hFFFF with no wrap.
REQ-025 state_out = 0 when sel >= N.
REQ-026 Neurons are fully independent; simultaneous spikes on all N neurons are legal and are all counted.

Reset
REQ-027 rst_n=0 asynchronously clears all state, refractory counters, spike and spike_cnt to 0, regardless of ena or clk.
REQ-028 Reset asserted mid-refractory or mid-integration discards all progress; the first enabled edge after release evaluates from state 0 with refrac 0.

Verification
REQ-029 Test parameters are N=4, W=8, LEAK_SHIFT=3, REFRAC=2.
REQ-030 Integrate and fire: neuron 0 current=40, thresh=100, mode 0, ena=1 -> state 40, 75, then 0 with spike[0]=1 for one cycle; state held 0 for 2 cycles; then 40; spike_cnt=1.
REQ-031 Subtract mode: current=60, thresh=100, mode 1 -> state 60, then 13 with spike=1 (113-100).
REQ-032 Saturation and disable: current=255, thresh=0 -> state 255 and holds 255; no spike; spike_cnt stays 0.
REQ-033 Simultaneous spikes and counter saturation: all 4 neurons current=255, thresh=1, REFRAC=0 -> spike=4'hF every cycle, spike_cnt +4 per cycle; force near 16'hFFFF -> holds 16'hFFFF.
REQ-034 Enable and reset: deassert ena for 5 cycles mid-refractory -> state, refrac and count frozen, spike=0; assert rst_n=0 between clock edges -> all outputs 0 immediately; sel=5 -> state_out=0.

Source files
------------

// File: rtl/lif_array_if.sv
// Bus bundle for the leaky integrate-and-fire neuron array: control, per-neuron
// currents, readout select and the spike/state/count results.
interface lif_array_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic             ena;
    logic [N*W-1:0]   current;
    logic [W-1:0]     thresh;
    logic             reset_mode;
    logic [SW-1:0]    sel;
    logic [N-1:0]     spike;
    logic [W-1:0]     state_out;
    logic [15:0]      spike_cnt;

    modport master (
        output ena, current, thresh, reset_mode, sel,
        input  spike, state_out, spike_cnt
    );

    modport slave (
        input  ena, current, thresh, reset_mode, sel,
        output spike, state_out, spike_cnt
    );
endinterface

// File: rtl/lif_array.sv
// Array of N independent leaky integrate-and-fire neurons with refractory
// hold, two post-spike reset modes and a saturating population spike counter.
module lif_array #(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    lif_array_if.slave    bus
);
    localparam int         SW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] REFRAC_V = 4'(REFRAC);

    logic [W-1:0]  state_r      [N];
    logic [3:0]    refrac_r     [N];
    logic [N-1:0]  spike_r;
    logic [15:0]   cnt_r;

    logic [W:0]    sum_s        [N];
    logic [W-1:0]  cand_s       [N];
    logic [W-1:0]  state_nxt_s  [N];
    logic [3:0]    refrac_nxt_s [N];
    logic [N-1:0]  fire_s;
    logic [15:0]   pop_s;
    logic [16:0]   cnt_sum_s;
    logic [15:0]   cnt_nxt_s;
    logic [W-1:0]  state_out_s;

    // Per-neuron leak/integrate, fire decision and next state/refractory value
    always_comb begin
        fire_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            // Leak never exceeds state, so the W+1 bit sum cannot underflow
            sum_s[i] = {1'b0, state_r[i]} - {1'b0, (state_r[i] >> LEAK_SHIFT)}
                     + {1'b0, bus.current[i*W +: W]};
            cand_s[i] = sum_s[i][W] ? {W{1'b1}} : sum_s[i][W-1:0];
            state_nxt_s[i]  = state_r[i];
            refrac_nxt_s[i] = refrac_r[i];
            if (!bus.ena) begin
                state_nxt_s[i] = state_r[i];
            end else if (refrac_r[i] != 4'd0) begin
                refrac_nxt_s[i] = refrac_r[i] - 4'd1;
            end else if ((bus.thresh != {W{1'b0}}) && (cand_s[i] >= bus.thresh)) begin
                fire_s[i]       = 1'b1;
                refrac_nxt_s[i] = REFRAC_V;
                state_nxt_s[i]  = bus.reset_mode ? (cand_s[i] - bus.thresh) : {W{1'b0}};
            end else begin
                state_nxt_s[i] = cand_s[i];
            end
        end
    end

    // Population count of this edge's spikes folded into the saturating counter
    always_comb begin
        pop_s = 16'd0;
        for (int i = 0; i < N; i++) begin
            pop_s = pop_s + {15'd0, fire_s[i]};
        end
        cnt_sum_s = {1'b0, cnt_r} + {1'b0, pop_s};
        cnt_nxt_s = cnt_sum_s[16] ? 16'hFFFF : cnt_sum_s[15:0];
    end

    // Neuron state, refractory counters, spike flops and spike counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                state_r[i]  <= {W{1'b0}};
                refrac_r[i] <= 4'd0;
            end
            spike_r <= {N{1'b0}};
            cnt_r   <= 16'd0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_r[i]  <= state_nxt_s[i];
                refrac_r[i] <= refrac_nxt_s[i];
            end
            spike_r <= fire_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Readout mux; an out-of-range select matches no neuron and reads zero
    always_comb begin
        state_out_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            state_out_s = (bus.sel == SW'(i)) ? state_r[i] : state_out_s;
        end
    end

    assign bus.spike     = spike_r;
    assign bus.state_out = state_out_s;
    assign bus.spike_cnt = cnt_r;
endmodule

// File: tb/tb_lif_array.sv
// Bench for lif_array: three instances (REFRAC=2, REFRAC=0, N=5) share one
// stimulus stream and are compared every cycle against an arithmetic model.
module tb_lif_array;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    lif_array_if #(.N(4), .W(8)) bus_a ();
    lif_array_if #(.N(4), .W(8)) bus_b ();
    lif_array_if #(.N(5), .W(8)) bus_c ();

    lif_array #(.N(4), .W(8), .LEAK_SHIFT(3), .REFRAC(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    lif_array #(.N(4), .W(8), .LEAK_SHIFT(3), .REFRAC(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    lif_array #(.N(5), .W(8), .LEAK_SHIFT(3), .REFRAC(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    always #5 clk = ~clk;

    int nn [3] = '{4, 4, 5};
    int rp [3] = '{2, 0, 2};

    int m_st [3][5];
    int m_rf [3][5];
    int m_sp [3][5];
    int m_cnt[3];

    bit ena;
    bit mode;
    int thr;
    int cur  [5];
    int sel_v[3];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus_a.ena = ena; bus_b.ena = ena; bus_c.ena = ena;
        bus_a.thresh = 8'(thr); bus_b.thresh = 8'(thr); bus_c.thresh = 8'(thr);
        bus_a.reset_mode = mode; bus_b.reset_mode = mode; bus_c.reset_mode = mode;
        for (int i = 0; i < 4; i++) begin
            bus_a.current[i*8 +: 8] = 8'(cur[i]);
            bus_b.current[i*8 +: 8] = 8'(cur[i]);
        end
        for (int i = 0; i < 5; i++) bus_c.current[i*8 +: 8] = 8'(cur[i]);
        bus_a.sel = 2'(sel_v[0]);
        bus_b.sel = 2'(sel_v[1]);
        bus_c.sel = 3'(sel_v[2]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            for (int i = 0; i < 5; i++) begin
                m_st[k][i] = 0; m_rf[k][i] = 0; m_sp[k][i] = 0;
            end
        end
    endtask

    task automatic model_step();
        int v;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < nn[k]; i++) begin
                m_sp[k][i] = 0;
                if (ena) begin
                    if (m_rf[k][i] > 0) begin
                        m_rf[k][i] = m_rf[k][i] - 1;
                    end else begin
                        v = m_st[k][i] - m_st[k][i] / 8 + cur[i];
                        if (v > 255) v = 255;
                        if (thr != 0 && v >= thr) begin
                            m_sp[k][i] = 1;
                            m_rf[k][i] = rp[k];
                            m_st[k][i] = mode ? (v - thr) : 0;
                            if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
                        end else begin
                            m_st[k][i] = v;
                        end
                    end
                end
            end
        end
    endtask

    function automatic int exp_spk(int k);
        int r = 0;
        for (int i = 0; i < nn[k]; i++) r = r + m_sp[k][i] * (1 << i);
        return r;
    endfunction

    function automatic int exp_so(int k);
        return (sel_v[k] < nn[k]) ? m_st[k][sel_v[k]] : 0;
    endfunction

    task automatic compare();
        chk("a.spike",     int'(bus_a.spike),     exp_spk(0));
        chk("a.state_out", int'(bus_a.state_out), exp_so(0));
        chk("a.spike_cnt", int'(bus_a.spike_cnt), m_cnt[0]);
        chk("b.spike",     int'(bus_b.spike),     exp_spk(1));
        chk("b.state_out", int'(bus_b.state_out), exp_so(1));
        chk("b.spike_cnt", int'(bus_b.spike_cnt), m_cnt[1]);
        chk("c.spike",     int'(bus_c.spike),     exp_spk(2));
        chk("c.state_out", int'(bus_c.state_out), exp_so(2));
        chk("c.spike_cnt", int'(bus_c.spike_cnt), m_cnt[2]);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            compare();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        ena = 1'b0; mode = 1'b0; thr = 0;
        for (int i = 0; i < 5; i++) cur[i] = 0;
        for (int k = 0; k < 3; k++) sel_v[k] = 0;
        drive();
        #1;
        do_reset();
        chk("rst.a.cnt",   int'(bus_a.spike_cnt), 0);
        chk("rst.a.state", int'(bus_a.state_out), 0);
        chk("rst.a.spike", int'(bus_a.spike),     0);

        // integrate and fire, reset-to-zero, refractory hold
        ena = 1'b1; thr = 100; cur[0] = 40; drive();
        step(1); chk("if.s1", int'(bus_a.state_out), 40);
        step(1); chk("if.s2", int'(bus_a.state_out), 75);
        step(1); chk("if.s3", int'(bus_a.state_out), 0);
                 chk("if.spk", int'(bus_a.spike), 1);
        step(1); chk("if.r1", int'(bus_a.state_out), 0);
                 chk("if.r1spk", int'(bus_a.spike), 0);
        step(1); chk("if.r2", int'(bus_a.state_out), 0);
        step(1); chk("if.s6", int'(bus_a.state_out), 40);
                 chk("if.cnt", int'(bus_a.spike_cnt), 1);

        // subtract-threshold mode
        do_reset();
        cur[0] = 60; mode = 1'b1; drive();
        step(1); chk("sub.s1", int'(bus_a.state_out), 60);
        step(1); chk("sub.s2", int'(bus_a.state_out), 13);
                 chk("sub.spk", int'(bus_a.spike), 1);

        // saturation with firing disabled, out-of-range readout
        do_reset();
        cur[0] = 255; mode = 1'b0; thr = 0; drive();
        step(1); chk("sat.s1", int'(bus_a.state_out), 255);
        step(1); chk("sat.s2", int'(bus_a.state_out), 255);
                 chk("sat.cnt", int'(bus_a.spike_cnt), 0);
                 chk("sat.spk", int'(bus_a.spike), 0);
        sel_v[2] = 5; drive(); #1;
        chk("sel.oor", int'(bus_c.state_out), 0);
        sel_v[2] = 0; drive(); #1;
        chk("sel.in", int'(bus_c.state_out), 255);
        step(1);

        // enable freeze mid-refractory
        do_reset();
        cur[0] = 40; thr = 100; drive();
        step(3); chk("frz.fire", int'(bus_a.spike), 1);
        step(1);
        ena = 1'b0; drive();
        step(5); chk("frz.state", int'(bus_a.state_out), 0);
                 chk("frz.cnt",   int'(bus_a.spike_cnt), 1);
                 chk("frz.spk",   int'(bus_a.spike), 0);
        ena = 1'b1; drive();
        step(1); chk("frz.r", int'(bus_a.state_out), 0);
        step(1); chk("frz.int", int'(bus_a.state_out), 40);
        step(2); chk("frz.cnt2", int'(bus_a.spike_cnt), 2);
        step(1);

        // async reset between edges while refractory
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.cnt",   int'(bus_a.spike_cnt), 0);
        chk("arst.state", int'(bus_a.state_out), 0);
        compare();
        @(negedge clk);
        rst_n = 1'b1;
        step(1); chk("arst.rel", int'(bus_a.state_out), 40);

        // all neurons firing together, counter saturation
        do_reset();
        for (int i = 0; i < 5; i++) cur[i] = 255;
        thr = 1; drive();
        step(1); chk("all.spk", int'(bus_b.spike), 15);
                 chk("all.c1",  int'(bus_b.spike_cnt), 4);
        step(1); chk("all.c2",  int'(bus_b.spike_cnt), 8);
                 chk("all.spk2", int'(bus_b.spike), 15);
        step(16390);
        chk("all.satcnt", int'(bus_b.spike_cnt), 65535);
        chk("all.satspk", int'(bus_b.spike), 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
